rr_op_sequencer: RTL and testbench

- Control-step sequencer for the datapath; replaces hand-sequenced T0..T5 strobes with a hardware FSM.
- Performs instruction fetch (T0–T2), then a register-register execute (T3–T5, plus T6 for MUL/DIV).
- Drives the datapath's one-hot bus-select and register-enable strobes.
- Generalised over register-file size and opcode width. Adds memory wait states, MUL/DIV HI/LO writeback, illegal-opcode trap and back-to-back issue.

---
 rtl/rr_op_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_rr_op_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_op_sequencer.sv
// rr_op_sequencer: control-step FSM that fetches one instruction (T0-T2) and
// executes a register-register operation (T3-T5, plus T6 for MUL/DIV HI/LO).
// Strobes are Moore outputs decoded from the state register and the IR fields.
// Optional build macro: FETCH_WAIT_EN holds T1 until mem_ready is seen.
module rr_op_sequencer #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned OPC_W    = 5,
   parameter int unsigned INSTR_W  = 32
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                start,
   input  logic                mem_ready,
   input  logic [INSTR_W-1:0]  ir,
   output logic                PCout,
   output logic                MARin,
   output logic                IncPC,
   output logic                PCin,
   output logic                Read,
   output logic                MDRin,
   output logic                MDRout,
   output logic                IRin,
   output logic                Yin,
   output logic                Zin,
   output logic                Zlowout,
   output logic                Zhighout,
   output logic                HIin,
   output logic                LOin,
   output logic [NUM_REGS-1:0] Rout,
   output logic [NUM_REGS-1:0] Rin,
   output logic [OPC_W-1:0]    alu_op,
   output logic                busy,
   output logic                done,
   output logic                illegal
);

   localparam int unsigned REG_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned IDX_W   = REG_W + 1;
   localparam int unsigned OPC_LSB = INSTR_W - OPC_W;
   localparam int unsigned RA_LSB  = OPC_LSB - REG_W;
   localparam int unsigned RB_LSB  = RA_LSB - REG_W;
   localparam int unsigned RC_LSB  = RB_LSB - REG_W;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_T6   = 3'd7
   } state_t;

   state_t state;
   state_t state_next;

   logic [OPC_W-1:0] opcode;
   logic [REG_W-1:0] ra;
   logic [REG_W-1:0] rb;
   logic [REG_W-1:0] rc;
   logic             is_alu;
   logic             is_hilo;
   logic             fields_ok;
   logic             bad_instr;
   logic             t1_first;
   logic             unused_in;

   // Field extraction from the IR fed back by the datapath
   assign opcode = ir[INSTR_W-1 -: OPC_W];
   assign ra     = ir[RA_LSB +: REG_W];
   assign rb     = ir[RB_LSB +: REG_W];
   assign rc     = ir[RC_LSB +: REG_W];

   // Immediate/unused low IR bits are not needed by the sequencer
   assign unused_in = ^{mem_ready, ir[RC_LSB-1:0]};

   // Opcode class decode; anything outside the two classes traps
   always_comb begin
      is_alu  = 1'b0;
      is_hilo = 1'b0;
      case (opcode)
         OPC_W'(3), OPC_W'(4), OPC_W'(5), OPC_W'(6),
         OPC_W'(7), OPC_W'(8), OPC_W'(9), OPC_W'(10): is_alu  = 1'b1;
         OPC_W'(14), OPC_W'(15):                      is_hilo = 1'b1;
         default: ;
      endcase
   end

   // Register indices must address an implemented register
   assign fields_ok = ({1'b0, ra} < IDX_W'(NUM_REGS)) &&
                      ({1'b0, rb} < IDX_W'(NUM_REGS)) &&
                      ({1'b0, rc} < IDX_W'(NUM_REGS));
   assign bad_instr = !(is_alu || is_hilo) || !fields_ok;

`ifdef FETCH_WAIT_EN
   logic t1_again;

   // Remembers that the next cycle is a repeated T1, so PC updates only once
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         t1_again <= 1'b0;
      end else begin
         t1_again <= (state == S_T1) && !mem_ready;
      end
   end

   assign t1_first = !t1_again;
`else
   assign t1_first = 1'b1;
`endif

   // State register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: state_next = start ? S_T0 : S_IDLE;
         S_T0:   state_next = S_T1;
`ifdef FETCH_WAIT_EN
         S_T1:   state_next = mem_ready ? S_T2 : S_T1;
`else
         S_T1:   state_next = S_T2;
`endif
         S_T2:   state_next = S_T3;
         S_T3:   state_next = bad_instr ? S_IDLE : S_T4;
         S_T4:   state_next = S_T5;
         S_T5: begin
            if (is_hilo) begin
               state_next = S_T6;
            end else begin
               state_next = start ? S_T0 : S_IDLE;
            end
         end
         S_T6:   state_next = start ? S_T0 : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Strobe decode from the current state and IR fields
   always_comb begin
      PCout    = 1'b0;
      MARin    = 1'b0;
      IncPC    = 1'b0;
      PCin     = 1'b0;
      Read     = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zin      = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      Rout     = '0;
      Rin      = '0;
      alu_op   = '0;
      busy     = (state != S_IDLE);
      done     = 1'b0;
      illegal  = 1'b0;
      case (state)
         S_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1: begin
            Read    = 1'b1;
            MDRin   = 1'b1;
            Zlowout = t1_first;
            PCin    = t1_first;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            if (bad_instr) begin
               illegal = 1'b1;
            end else begin
               Rout = NUM_REGS'(1) << rb;
               Yin  = 1'b1;
            end
         end
         S_T4: begin
            Rout   = NUM_REGS'(1) << rc;
            Zin    = 1'b1;
            alu_op = opcode;
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (is_hilo) begin
               LOin = 1'b1;
            end else begin
               Rin  = NUM_REGS'(1) << ra;
               done = 1'b1;
            end
         end
         S_T6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
            done     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rr_op_sequencer.sv
// tb_rr_op_sequencer: directed plus randomized instruction stream; expected
// strobes per cycle are expanded from the instruction-level step rules.
module tb_rr_op_sequencer;

   typedef struct packed {
      logic        pcout, marin, incpc, pcin, read, mdrin, mdrout, irin;
      logic        yin, zin, zlowout, zhighout, hiin, loin, busy, done, illegal;
      logic [15:0] rout;
      logic [15:0] rin;
      logic [4:0]  alu_op;
   } strobe_t;

   logic        clk;
   logic        clr;
   logic        start;
   logic        mem_ready;
   logic [31:0] ir;
   logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
   logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
   logic [15:0] Rout;
   logic [15:0] Rin;
   logic [4:0]  alu_op;
   logic        busy, done, illegal;

   int checks;
   int errors;

   strobe_t     exp_q[$];
   bit          start_q[$];
   bit          mr_q[$];
   logic [31:0] ir_q[$];
   bit          prev_illegal;

   rr_op_sequencer dut (
      .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
      .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
      .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
      .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
      .Rout(Rout), .Rin(Rin), .alu_op(alu_op), .busy(busy), .done(done),
      .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic strobe_t observed();
      strobe_t s;
      s = '{pcout: PCout, marin: MARin, incpc: IncPC, pcin: PCin, read: Read,
            mdrin: MDRin, mdrout: MDRout, irin: IRin, yin: Yin, zin: Zin,
            zlowout: Zlowout, zhighout: Zhighout, hiin: HIin, loin: LOin,
            busy: busy, done: done, illegal: illegal, rout: Rout, rin: Rin,
            alu_op: alu_op};
      return s;
   endfunction

   function automatic bit rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input strobe_t s, input bit st, input bit mr, input logic [31:0] instr);
      exp_q.push_back(s);
      start_q.push_back(st);
      mr_q.push_back(mr);
      ir_q.push_back(instr);
   endtask

   task automatic add_idle(input int n);
      for (int k = 0; k < n; k++) push('0, 1'b0, rnd_bit(), 32'h0);
   endtask

   // Expand one instruction into its per-cycle expected strobe vectors.
   // gap = idle cycles before it (0 = issued from the previous final step).
   task automatic add_txn(input logic [31:0] instr, input int w, input int gap);
      strobe_t     s;
      int unsigned op, ra, rb, rc;
      bit          alu, hilo, mr;
      op   = instr >> 27;
      ra   = (instr >> 23) & 32'hF;
      rb   = (instr >> 19) & 32'hF;
      rc   = (instr >> 15) & 32'hF;
      alu  = (op >= 3) && (op <= 10);
      hilo = (op == 14) || (op == 15);
      if (gap == 0) start_q[start_q.size()-1] = 1'b1;
      for (int k = 0; k < gap; k++) push('0, (k == gap - 1), rnd_bit(), instr);
      s = '0; s.busy = 1; s.pcout = 1; s.marin = 1; s.incpc = 1; s.zin = 1;
      push(s, rnd_bit(), rnd_bit(), instr);
      for (int k = 0; k <= w; k++) begin
         s = '0; s.busy = 1; s.read = 1; s.mdrin = 1;
         if (k == 0) begin s.zlowout = 1; s.pcin = 1; end
`ifdef FETCH_WAIT_EN
         mr = (k == w);
`else
         mr = rnd_bit();
`endif
         push(s, rnd_bit(), mr, instr);
      end
      s = '0; s.busy = 1; s.mdrout = 1; s.irin = 1;
      push(s, rnd_bit(), rnd_bit(), instr);
      if (!alu && !hilo) begin
         s = '0; s.busy = 1; s.illegal = 1;
         push(s, rnd_bit(), rnd_bit(), instr);
         prev_illegal = 1'b1;
         return;
      end
      prev_illegal = 1'b0;
      s = '0; s.busy = 1; s.yin = 1; s.rout = 16'(1) << rb;
      push(s, rnd_bit(), rnd_bit(), instr);
      s = '0; s.busy = 1; s.zin = 1; s.rout = 16'(1) << rc; s.alu_op = 5'(op);
      push(s, rnd_bit(), rnd_bit(), instr);
      s = '0; s.busy = 1; s.zlowout = 1;
      if (alu) begin
         s.rin = 16'(1) << ra; s.done = 1;
         push(s, 1'b0, rnd_bit(), instr);
      end else begin
         s.loin = 1;
         push(s, rnd_bit(), rnd_bit(), instr);
         s = '0; s.busy = 1; s.zhighout = 1; s.hiin = 1; s.done = 1;
         push(s, 1'b0, rnd_bit(), instr);
      end
   endtask

   initial begin
      logic [31:0] instr;
      int unsigned op, pick;
      int          gap, w, w3;
      checks = 0;
      errors = 0;
      prev_illegal = 1'b0;
      clr = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = 32'h0;
`ifdef FETCH_WAIT_EN
      w3 = 3;
`else
      w3 = 0;
`endif

      // Build the expected trace: directed cases first, then random ones
      add_idle(1);
      add_txn(32'h18918000, 0, 2);    // ADD R1,R2,R3
      add_txn(32'h70918000, 0, 1);    // MUL R1,R2,R3
      add_txn(32'hF8000000, 0, 1);    // opcode 31
      add_txn(32'h18918000, 0, 1);    // two ADDs back to back
      add_txn(32'h18918000, 0, 0);
      add_txn(32'h18918000, w3, 1);   // fetch wait states
      for (int t = 0; t < 60; t++) begin
         pick = $urandom_range(0, 9);
         if (pick <= 5)      op = $urandom_range(3, 10);
         else if (pick <= 7) op = $urandom_range(14, 15);
         else                op = $urandom_range(0, 31);
         instr = ($urandom() & 32'h07FF_FFFF) | (op << 27);
         gap   = prev_illegal ? $urandom_range(1, 3) : $urandom_range(0, 3);
`ifdef FETCH_WAIT_EN
         w = $urandom_range(0, 3);
`else
         w = 0;
`endif
         add_txn(instr, w, gap);
      end
      add_idle(3);

      // Reset state
      repeat (2) @(negedge clk);
      checks++;
      assert (observed() === strobe_t'('0)) else begin
         errors++;
         $error("FAIL reset obs=%h exp=%h", observed(), strobe_t'('0));
      end
      clr = 1'b1;

      // Replay the trace, one comparison per cycle
      for (int c = 0; c < exp_q.size(); c++) begin
         checks++;
         assert (observed() === exp_q[c]) else begin
            errors++;
            $error("FAIL cycle%0d obs=%h exp=%h", c, observed(), exp_q[c]);
         end
         start     = start_q[c];
         mem_ready = mr_q[c];
         if (exp_q[c].irin) ir = ir_q[c];
         @(negedge clk);
      end

      // Asynchronous clear in the middle of T4
      ir = 32'h18918000; mem_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      assert ({Zin, Rout, alu_op} === {1'b1, 16'h0008, 5'd3}) else begin
         errors++;
         $error("FAIL pre_clr_t4 obs=%h exp=%h", {Zin, Rout, alu_op}, {1'b1, 16'h0008, 5'd3});
      end
      #2 clr = 1'b0;
      #1;
      checks++;
      assert (observed() === strobe_t'('0)) else begin
         errors++;
         $error("FAIL async_clr obs=%h exp=%h", observed(), strobe_t'('0));
      end
      @(negedge clk);
      clr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         assert (observed() === strobe_t'('0)) else begin
            errors++;
            $error("FAIL post_clr_idle%0d obs=%h exp=%h", k, observed(), strobe_t'('0));
         end
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
